inst_decode_queue: RTL and testbench
====================================

# inst_decode_queue

Buffered, handshaked RV32I instruction decode stage sitting between instruction fetch and issue. Raw instruction words and their PCs enter a parametrised FIFO. The head entry is decoded into a one-hot class, register indices, funct3, a sign-extended immediate and an illegal flag, then held in a registered output stage with valid/ready flow control. A synchronous flush discards all buffered and pending work on redirect.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PC_W, 32, PC width.

- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous discard of FIFO and output stage.
- in_valid  input  1  fetch offers in_inst/in_pc.
- in_ready  output  1  queue can accept.
- in_inst  input  32  raw instruction.
- in_pc  input  PC_W  instruction PC.
- out_valid  output  1  decoded entry present.
- out_ready  input  1  issue consumes entry.
- out_pc  output  PC_W  PC of decoded entry.
- out_class  output  11  one-hot: [0]LUI [1]AUIPC [2]JAL [3]JALR [4]BRANCH [5]LOAD [6]STORE [7]OPIMM [8]OP [9]MISC_MEM [10]SYSTEM.
- out_funct3  output  3  inst[14:12].
- out_rd, out_rs1, out_rs2  output  5 each  inst[11:7], inst[19:15], inst[24:20].
- out_imm  output  32  sign-extended immediate for the I/S/B/U/J format; 0 for R-type.
- out_illegal  output  1  entry is not a legal instruction.
- count  output  $clog2(DEPTH)+1  FIFO occupancy; excludes the output stage.

## Operation
- FIFO stores {inst, pc}. The write pointer, read pointer and count wrap modulo DEPTH.
- A push occurs on in_valid && in_ready. in_ready = (count != DEPTH) && !flush.
- The output stage loads from the FIFO head when the FIFO is not empty and (!out_valid || out_ready). The same edge pops the head.
- Push and pop in the same cycle leave count unchanged. With a full FIFO, in_ready is 0, so push-with-pop at full does not occur.
- Decode is performed from the FIFO head before the output register.
- Illegal conditions:
  - inst[1:0] != 2'b11.
  - Opcode outside the 11 classes.
  - JALR funct3 != 0.
  - BRANCH funct3 is 010 or 011.
  - LOAD funct3 is 011, 110 or 111.
  - STORE funct3 >= 011.
  - OP funct7 is not 0x00/0x20, or funct7 0x20 with funct3 other than 000/101.
  - OPIMM funct3 001 with funct7 != 0.
  - OPIMM funct3 101 with funct7 not 0x00/0x20.
  - MISC_MEM funct3 > 001.
- An illegal entry presents out_illegal=1, out_class=0 and out_imm=0. out_pc, out_rd, out_rs1, out_rs2 and out_funct3 still show the raw fields. The entry completes a normal handshake.
- Flush has priority over push and pop. The next edge gives count=0, pointers=0 and out_valid=0. Input presented in the flush cycle is not accepted.

## Timing
- Reset (async assert, release at edge): every output register is 0, including out_valid, out_class, out_imm, out_illegal, out_pc and count. in_ready=1.
- Latency: a push in cycle c gives out_valid=1 in cycle c+2 when the FIFO and the output stage are empty.
- Throughput: one instruction per cycle with in_valid=out_ready=1 held.
- The output stage holds all out_* values stable while out_valid && !out_ready.
- Capacity with out_ready=0: DEPTH+1 instructions, 1 in the output stage plus DEPTH in the FIFO. in_ready falls when count reaches DEPTH.
- Asserting rst_n low mid-stream returns all state to the reset values immediately, without waiting for a clock edge.

## Configuration
- DECODE_SYSTEM_EN defined:
  - opcode 0x73 decodes as class[10].
  - Legal funct3 values are 000 (ECALL, EBREAK, MRET, WFI, by imm), 001-011 and 101-111 (CSR).
  - out_imm carries the zero-extended CSR address inst[31:20].
- DECODE_SYSTEM_EN not defined: opcode 0x73 is illegal and class[10] is never set.

## Test plan
- Reset: hold rst_n=0 with random inputs. Required: out_valid=0, count=0, in_ready=1, all out_* = 0.
- Legal stream with out_ready=1:
  - 0x00000797 -> AUIPC, rd=15, imm=0.
  - 0x02c78793 -> OPIMM, rd=15, rs1=15, imm=44.
  - 0x1a5000ef -> JAL, rd=1, imm=0x9A4.
  - 0x00112623 -> STORE, rs1=2, rs2=1, imm=12.
  - 0x04079263 -> BRANCH, funct3=1, rs1=15, rs2=0, imm=68.
  - 0x07f56513 -> OPIMM, funct3=6, rd=10, rs1=10, imm=127.
  - Each appears 2 cycles after its push; out_pc matches the pushed PC.
- Backpressure with DEPTH=4 and out_ready=0: 5 pushes are accepted, then in_ready=0 and count=4. Required: 6 consecutive out_ready pulses drain the entries in order with stable outputs between pulses.
- Flush with 3 entries buffered and out_valid=1: assert flush with in_valid=1 for 1 cycle. Required: the next cycle has count=0 and out_valid=0; the input offered in the flush cycle never appears at the output.
- Illegal: push 0x00000000 and 0x8000007F. Required: each gives out_illegal=1, out_class=0, out_imm=0, and each is consumed normally.
- Macro: push 0x30200073. Required: class[10] and imm=0x302 with DECODE_SYSTEM_EN defined; out_illegal=1 without it.

Source files
------------

// File: rtl/inst_decode_queue.sv
// -----------------------------------------------------------------------------
// inst_decode_queue
//
// Buffered RV32I decode stage between instruction fetch and issue. Raw
// instruction words and their PCs are queued in a DEPTH-entry FIFO. The FIFO
// head is decoded combinationally and captured into a registered output stage
// with valid/ready flow control. A synchronous flush drops all queued work
// and the output stage.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   PC_W   PC width
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   flush            synchronous discard of FIFO and output stage
//   in_valid/ready   fetch handshake; in_inst, in_pc carried with it
//   out_valid/ready  issue handshake for the decoded entry
//   out_pc           PC of the decoded entry
//   out_class        one-hot class: [0]LUI [1]AUIPC [2]JAL [3]JALR [4]BRANCH
//                    [5]LOAD [6]STORE [7]OPIMM [8]OP [9]MISC_MEM [10]SYSTEM
//   out_funct3, out_rd, out_rs1, out_rs2  raw instruction fields
//   out_imm          sign-extended immediate (0 for R-type and illegal)
//   out_illegal      entry is not a legal instruction
//   count            FIFO occupancy, output stage excluded
//
// Build option
//   DECODE_SYSTEM_EN  when defined, opcode 0x73 decodes as SYSTEM with the
//                     zero-extended CSR address in out_imm; otherwise 0x73 is
//                     reported illegal.
// -----------------------------------------------------------------------------
module inst_decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_inst,
   input  logic [PC_W-1:0]        in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PC_W-1:0]        out_pc,
   output logic [10:0]            out_class,
   output logic [2:0]             out_funct3,
   output logic [4:0]             out_rd,
   output logic [4:0]             out_rs1,
   output logic [4:0]             out_rs2,
   output logic [31:0]            out_imm,
   output logic                   out_illegal,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = 32 + PC_W;

   // Full 7-bit opcodes (low two bits are always 2'b11 for 32-bit encodings)
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Bit positions within the one-hot class vector
   localparam int CLS_LUI      = 0;
   localparam int CLS_AUIPC    = 1;
   localparam int CLS_JAL      = 2;
   localparam int CLS_JALR     = 3;
   localparam int CLS_BRANCH   = 4;
   localparam int CLS_LOAD     = 5;
   localparam int CLS_STORE    = 6;
   localparam int CLS_OPIMM    = 7;
   localparam int CLS_OP       = 8;
   localparam int CLS_MISC_MEM = 9;
`ifdef DECODE_SYSTEM_EN
   localparam int CLS_SYSTEM   = 10;
`endif

   // Registered output stage, kept together so reset/hold/load stay uniform
   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] pc;
      logic [10:0]     cls;
      logic [2:0]      funct3;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [31:0]     imm;
      logic            illegal;
   } stage_t;

   // ---------------------------------------------------------------------------
   // FIFO storage and pointers
   // ---------------------------------------------------------------------------
   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   stage_t             stage_q, stage_d;

   logic push;
   logic pop;

   // Flush blocks acceptance so the word offered alongside it is never queued.
   assign in_ready = (count_q != CNT_W'(DEPTH)) && !flush;
   assign push     = in_valid && in_ready;
   // The head moves into the output stage whenever that stage is free or is
   // being consumed this cycle.
   assign pop      = (count_q != '0) && (!stage_q.valid || out_ready) && !flush;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: the storage array is deliberately left out of reset; a slot is
   // only read after it has been written, and no reset keeps it RAM-mappable.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_inst, in_pc};
   end

   // ---------------------------------------------------------------------------
   // Decode of the FIFO head
   // ---------------------------------------------------------------------------
   logic [ENTRY_W-1:0] head;
   logic [31:0]        head_inst;
   logic [PC_W-1:0]    head_pc;
   logic [2:0]         head_f3;
   logic [6:0]         head_f7;
   logic [31:0]        imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [10:0]        dec_class;
   logic [31:0]        dec_imm;
   logic               dec_illegal;

   assign head      = mem_q[rd_ptr_q];
   assign head_inst = head[ENTRY_W-1:PC_W];
   assign head_pc   = head[PC_W-1:0];
   assign head_f3   = head_inst[14:12];
   assign head_f7   = head_inst[31:25];

   assign imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
   assign imm_s = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
   assign imm_b = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                   head_inst[30:25], head_inst[11:8], 1'b0};
   assign imm_u = {head_inst[31:12], 12'b0};
   assign imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                   head_inst[20], head_inst[30:21], 1'b0};

   always_comb begin
      dec_class   = '0;
      dec_imm     = '0;
      dec_illegal = 1'b0;
      if (head_inst[1:0] != 2'b11) begin
         dec_illegal = 1'b1;
      end else begin
         case (head_inst[6:0])
            OPC_LUI: begin
               dec_class[CLS_LUI] = 1'b1;
               dec_imm            = imm_u;
            end
            OPC_AUIPC: begin
               dec_class[CLS_AUIPC] = 1'b1;
               dec_imm              = imm_u;
            end
            OPC_JAL: begin
               dec_class[CLS_JAL] = 1'b1;
               dec_imm            = imm_j;
            end
            OPC_JALR: begin
               dec_class[CLS_JALR] = 1'b1;
               dec_imm             = imm_i;
               dec_illegal         = (head_f3 != 3'b000);
            end
            OPC_BRANCH: begin
               dec_class[CLS_BRANCH] = 1'b1;
               dec_imm               = imm_b;
               dec_illegal           = (head_f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
               dec_class[CLS_LOAD] = 1'b1;
               dec_imm             = imm_i;
               dec_illegal         = (head_f3 == 3'b011) || (head_f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
               dec_class[CLS_STORE] = 1'b1;
               dec_imm              = imm_s;
               dec_illegal          = (head_f3 >= 3'b011);
            end
            OPC_OPIMM: begin
               dec_class[CLS_OPIMM] = 1'b1;
               dec_imm              = imm_i;
               // Shift-immediates reuse imm[11:5] as funct7.
               dec_illegal = ((head_f3 == 3'b001) && (head_f7 != 7'h00)) ||
                             ((head_f3 == 3'b101) && (head_f7 != 7'h00) &&
                              (head_f7 != 7'h20));
            end
            OPC_OP: begin
               dec_class[CLS_OP] = 1'b1;
               // funct7 0x20 only exists for SUB and SRA.
               dec_illegal = !((head_f7 == 7'h00) ||
                               ((head_f7 == 7'h20) &&
                                ((head_f3 == 3'b000) || (head_f3 == 3'b101))));
            end
            OPC_MISC_MEM: begin
               dec_class[CLS_MISC_MEM] = 1'b1;
               dec_imm                 = imm_i;
               dec_illegal             = (head_f3 > 3'b001);
            end
`ifdef DECODE_SYSTEM_EN
            OPC_SYSTEM: begin
               dec_class[CLS_SYSTEM] = 1'b1;
               dec_imm               = {20'b0, head_inst[31:20]};
               dec_illegal           = (head_f3 == 3'b100);
            end
`else
            OPC_SYSTEM: begin
               dec_illegal = 1'b1;
            end
`endif
            default: begin
               dec_illegal = 1'b1;
            end
         endcase
      end
      // Illegal entries carry no class and no immediate.
      if (dec_illegal) begin
         dec_class = '0;
         dec_imm   = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Output stage
   // ---------------------------------------------------------------------------
   always_comb begin
      stage_d = stage_q;
      if (flush) begin
         stage_d.valid = 1'b0;
      end else if (pop) begin
         stage_d.valid   = 1'b1;
         stage_d.pc      = head_pc;
         stage_d.cls     = dec_class;
         stage_d.funct3  = head_f3;
         stage_d.rd      = head_inst[11:7];
         stage_d.rs1     = head_inst[19:15];
         stage_d.rs2     = head_inst[24:20];
         stage_d.imm     = dec_imm;
         stage_d.illegal = dec_illegal;
      end else if (out_ready) begin
         stage_d.valid = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         stage_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         stage_q  <= stage_d;
      end
   end

   assign out_valid   = stage_q.valid;
   assign out_pc      = stage_q.pc;
   assign out_class   = stage_q.cls;
   assign out_funct3  = stage_q.funct3;
   assign out_rd      = stage_q.rd;
   assign out_rs1     = stage_q.rs1;
   assign out_rs2     = stage_q.rs2;
   assign out_imm     = stage_q.imm;
   assign out_illegal = stage_q.illegal;
   assign count       = count_q;

endmodule

// File: tb/tb_inst_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_decode_queue
//
// Self-checking bench for inst_decode_queue. A queue-based reference model of
// the buffer plus an arithmetic RV32I decoder predicts every output; a
// compare process checks the DUT against it each cycle. Directed sequences
// pin the model with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_inst_decode_queue;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;

   logic                   clk       = 1'b0;
   logic                   rst_n     = 1'b0;
   logic                   flush     = 1'b0;
   logic                   in_valid  = 1'b0;
   logic [31:0]            in_inst   = '0;
   logic [PC_W-1:0]        in_pc     = '0;
   logic                   out_ready = 1'b0;
   logic                   in_ready;
   logic                   out_valid;
   logic [PC_W-1:0]        out_pc;
   logic [10:0]            out_class;
   logic [2:0]             out_funct3;
   logic [4:0]             out_rd, out_rs1, out_rs2;
   logic [31:0]            out_imm;
   logic                   out_illegal;
   logic [$clog2(DEPTH):0] count;

   inst_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_inst    (in_inst),
      .in_pc      (in_pc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pc     (out_pc),
      .out_class  (out_class),
      .out_funct3 (out_funct3),
      .out_rd     (out_rd),
      .out_rs1    (out_rs1),
      .out_rs2    (out_rs2),
      .out_imm    (out_imm),
      .out_illegal(out_illegal),
      .count      (count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------------------------------------------------------------------
   // Reference decoder: classify by the 5-bit major opcode, then build the
   // immediate arithmetically from signed fields.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [10:0] cls;
      logic [31:0] imm;
      logic        ill;
   } dec_t;

   function automatic dec_t ref_decode(input logic [31:0] w);
      dec_t        r;
      int          kind;
      bit          legal;
      int          v;
      logic [2:0]  f3;
      logic [6:0]  f7;
      f3    = w[14:12];
      f7    = w[31:25];
      kind  = -1;
      legal = 1'b1;
      v     = 0;
      if (w[1:0] == 2'b11) begin
         case (w[6:2])
            5'b01101: begin kind = 0; v = int'(w & 32'hFFFF_F000); end
            5'b00101: begin kind = 1; v = int'(w & 32'hFFFF_F000); end
            5'b11011: begin kind = 2; v = $signed({w[31], w[19:12], w[20], w[30:21]}); v = v * 2; end
            5'b11001: begin kind = 3; v = $signed(w[31:20]); legal = (f3 == 3'd0); end
            5'b11000: begin kind = 4; v = $signed({w[31], w[7], w[30:25], w[11:8]}); v = v * 2;
                            legal = !(f3 inside {3'd2, 3'd3}); end
            5'b00000: begin kind = 5; v = $signed(w[31:20]); legal = !(f3 inside {3'd3, 3'd6, 3'd7}); end
            5'b01000: begin kind = 6; v = $signed({w[31:25], w[11:7]}); legal = (f3 < 3'd3); end
            5'b00100: begin kind = 7; v = $signed(w[31:20]);
                            if (f3 == 3'd1) legal = (f7 == 7'h00);
                            else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20); end
            5'b01100: begin kind = 8; v = 0;
                            legal = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 inside {3'd0, 3'd5})); end
            5'b00011: begin kind = 9; v = $signed(w[31:20]); legal = (f3 <= 3'd1); end
`ifdef DECODE_SYSTEM_EN
            5'b11100: begin kind = 10; v = int'({20'b0, w[31:20]}); legal = (f3 != 3'd4); end
`endif
            default:  kind = -1;
         endcase
      end
      if (kind < 0 || !legal) begin
         r.cls = '0;
         r.imm = '0;
         r.ill = 1'b1;
      end else begin
         r.cls = 11'(1 << kind);
         r.imm = 32'(v);
         r.ill = 1'b0;
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Reference buffer: a queue for the FIFO plus one held slot.
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic [31:0]     inst;
      logic [PC_W-1:0] pc;
   } ent_t;

   ent_t            m_fifo[$];
   bit              m_valid = 1'b0;
   logic [31:0]     m_inst  = '0;
   logic [PC_W-1:0] m_pc    = '0;

   initial begin
      int   sz;
      bit   do_push, do_load;
      ent_t e;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_fifo.delete();
            m_valid = 1'b0;
         end else if (flush) begin
            m_fifo.delete();
            m_valid = 1'b0;
         end else begin
            sz      = m_fifo.size();
            do_push = in_valid && (sz != DEPTH);
            do_load = (sz > 0) && (!m_valid || out_ready);
            if (do_load) begin
               e       = m_fifo.pop_front();
               m_inst  = e.inst;
               m_pc    = e.pc;
               m_valid = 1'b1;
            end else if (out_ready) begin
               m_valid = 1'b0;
            end
            if (do_push) begin
               e.inst = in_inst;
               e.pc   = in_pc;
               m_fifo.push_back(e);
            end
         end
      end
   end

   // Compare process: DUT against model on every falling edge.
   initial begin
      dec_t d;
      forever begin
         @(negedge clk);
         if (rst_n && cmp_en) begin
            check("cmp.count", 32'(count), m_fifo.size());
            check("cmp.in_ready", 32'(in_ready), 32'((m_fifo.size() != DEPTH) && !flush));
            check("cmp.out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
               d = ref_decode(m_inst);
               check("cmp.out_pc", out_pc, m_pc);
               check("cmp.out_class", 32'(out_class), 32'(d.cls));
               check("cmp.out_imm", out_imm, d.imm);
               check("cmp.out_illegal", 32'(out_illegal), 32'(d.ill));
               check("cmp.out_funct3", 32'(out_funct3), 32'(m_inst[14:12]));
               check("cmp.out_rd", 32'(out_rd), 32'(m_inst[11:7]));
               check("cmp.out_rs1", 32'(out_rs1), 32'(m_inst[19:15]));
               check("cmp.out_rs2", 32'(out_rs2), 32'(m_inst[24:20]));
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Directed vectors with hand-decoded expectations
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [31:0] inst;
      logic [10:0] cls;
      logic [2:0]  f3;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        ill;
   } vec_t;

   vec_t vecs[6];

   // Push one word into an empty queue and check it two cycles later.
   task automatic single(input vec_t v, input logic [31:0] pc, input string tag);
      @(posedge clk); #1;
      in_valid = 1'b1; in_inst = v.inst; in_pc = pc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, ".early_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".pc"}, out_pc, pc);
      check({tag, ".class"}, 32'(out_class), 32'(v.cls));
      check({tag, ".funct3"}, 32'(out_funct3), 32'(v.f3));
      check({tag, ".rd"}, 32'(out_rd), 32'(v.rd));
      check({tag, ".rs1"}, 32'(out_rs1), 32'(v.rs1));
      check({tag, ".rs2"}, 32'(out_rs2), 32'(v.rs2));
      check({tag, ".imm"}, out_imm, v.imm);
      check({tag, ".illegal"}, 32'(out_illegal), 32'(v.ill));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [6:0]  opcs[11];
      opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
      w = $urandom;
      case ($urandom_range(0, 3))
         0: ;
         1: w = vecs[$urandom_range(0, 5)].inst;
         2: w[6:0] = opcs[$urandom_range(0, 10)];
         default: begin
            w[6:0]   = opcs[$urandom_range(7, 8)];
            w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
         end
      endcase
      return w;
   endfunction

   initial begin
      vec_t        t;
      int          acc;
      logic [31:0] pc_hold;

      vecs[0] = '{32'h00000797, 11'h002, 3'd0, 5'd15, 5'd0,  5'd0,  32'd0,     1'b0};
      vecs[1] = '{32'h02c78793, 11'h080, 3'd0, 5'd15, 5'd15, 5'd12, 32'd44,    1'b0};
      vecs[2] = '{32'h1a5000ef, 11'h004, 3'd0, 5'd1,  5'd0,  5'd5,  32'h9A4,   1'b0};
      vecs[3] = '{32'h00112623, 11'h040, 3'd2, 5'd12, 5'd2,  5'd1,  32'd12,    1'b0};
      vecs[4] = '{32'h04079263, 11'h010, 3'd1, 5'd4,  5'd15, 5'd0,  32'd68,    1'b0};
      vecs[5] = '{32'h07f56513, 11'h080, 3'd6, 5'd10, 5'd10, 5'd31, 32'd127,   1'b0};

      // Reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_inst = $urandom; in_pc = $urandom; out_ready = $urandom_range(0, 1);
         @(negedge clk);
         check("rst.out_valid", 32'(out_valid), 32'd0);
         check("rst.count", 32'(count), 32'd0);
         check("rst.in_ready", 32'(in_ready), 32'd1);
         check("rst.out_class", 32'(out_class), 32'd0);
         check("rst.out_imm", out_imm, 32'd0);
         check("rst.out_illegal", 32'(out_illegal), 32'd0);
         check("rst.out_pc", out_pc, 32'd0);
         check("rst.out_fields", {17'd0, out_funct3, out_rd, out_rs1, out_rs2}, 32'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // Legal stream, one at a time, literal expectations and latency
      for (int k = 0; k < 6; k++) single(vecs[k], 32'h1000 + 32'(k * 4), $sformatf("legal%0d", k));

      // Back-to-back stream: one result per cycle in order
      @(posedge clk); #1;
      for (int s = 0; s < 8; s++) begin
         if (s < 6) begin
            in_valid = 1'b1; in_inst = vecs[s].inst; in_pc = 32'h2000 + 32'(s * 4);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (s >= 2) begin
            check("stream.valid", 32'(out_valid), 32'd1);
            check("stream.pc", out_pc, 32'h2000 + 32'((s - 2) * 4));
         end
         @(posedge clk); #1;
      end
      idle(2);

      // Illegal encodings
      t = '{32'h00000000, 11'h000, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1};
      single(t, 32'h3000, "illegal_zero");
      t = '{32'h8000007F, 11'h000, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1};
      single(t, 32'h3004, "illegal_7f");

      // SYSTEM opcode: behaviour depends on the build option
`ifdef DECODE_SYSTEM_EN
      t = '{32'h30200073, 11'h400, 3'd0, 5'd0, 5'd0, 5'd2, 32'h302, 1'b0};
`else
      t = '{32'h30200073, 11'h000, 3'd0, 5'd0, 5'd0, 5'd2, 32'd0, 1'b1};
`endif
      single(t, 32'h3008, "system");
      idle(2);

      // Backpressure: DEPTH+1 accepted, then ordered drain with stable holds
      out_ready = 1'b0;
      acc       = 0;
      in_valid  = 1'b1;
      for (int s = 0; s < 8; s++) begin
         in_inst = vecs[acc % 6].inst;
         in_pc   = 32'h100 + 32'(acc * 4);
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("bp.accepted", 32'(acc), 32'(DEPTH + 1));
      check("bp.count", 32'(count), 32'(DEPTH));
      check("bp.in_ready", 32'(in_ready), 32'd0);
      for (int p = 0; p < 6; p++) begin
         @(posedge clk); #1;
         out_ready = 1'b0;
         @(negedge clk);
         pc_hold = out_pc;
         if (p < 5) begin
            check("bp.drain_valid", 32'(out_valid), 32'd1);
            check("bp.drain_pc", out_pc, 32'h100 + 32'(p * 4));
         end else begin
            check("bp.drained", 32'(out_valid), 32'd0);
         end
         @(posedge clk); #1;
         out_ready = 1'b1;
         @(negedge clk);
         if (p < 5) check("bp.hold_pc", out_pc, pc_hold);
      end
      @(posedge clk); #1;

      // Flush with 3 buffered entries and a loaded output stage
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_inst = vecs[k].inst; in_pc = 32'h4000 + 32'(k * 4);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("flush.pre_count", 32'(count), 32'd3);
      check("flush.pre_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00a00093; in_pc = 32'hDEAD0000;
      @(negedge clk);
      check("flush.in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("flush.count", 32'(count), 32'd0);
      check("flush.valid", 32'(out_valid), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("flush.no_ghost", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;

      // Randomized traffic with occasional flush and one mid-stream reset
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc == 1500) begin
            flush = 1'b0; in_valid = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check("arst.count", 32'(count), 32'd0);
            check("arst.out_valid", 32'(out_valid), 32'd0);
            check("arst.in_ready", 32'(in_ready), 32'd1);
            check("arst.out_pc", out_pc, 32'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
         flush     = ($urandom_range(0, 19) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_inst   = rand_inst();
         in_pc     = $urandom;
         @(posedge clk); #1;
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      idle(8);
      cmp_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
